// File: rtl/seg7_pkg.sv
// Shared widths and the active-high 7-segment pattern table (bit6 = a ... bit0 = g).
package seg7_pkg;

    localparam int SEG_W   = 7;
    localparam int DIGIT_W = 4;

    // Index 0 is the rightmost entry, so the list reads F down to 0.
    localparam logic [15:0][SEG_W-1:0] SEG_PATTERN = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] digit);
        return SEG_PATTERN[digit];
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Clock-enable prescaler: o_tick marks the last of every DIV_COUNT enabled cycles.
// i_en low freezes the count and suppresses the tick.
module seg7_prescaler #(
    parameter int DIV_COUNT = 27_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_COUNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by i_en so a frozen prescaler parked on LAST cannot cause a step.
    assign o_tick = i_en && (cnt_q == LAST);

endmodule

// File: rtl/seg7_counter.sv
// Up/down digit counter stepped by the prescaler tick, with registered 7-segment decode.
// Counter, display and wrap update one edge after the tick; SEG7_COMMON_ANODE_EN inverts segments.
module seg7_counter
    import seg7_pkg::*;
#(
    parameter int DIV_COUNT = 27_000_000,
    parameter int MAX_COUNT = 9
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_dir,
    input  logic               i_clear,
    output logic [DIGIT_W-1:0] o_counter,
    output logic [SEG_W-1:0]   o_display,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               e,
    output logic               f,
    output logic               g,
    output logic               o_tick,
    output logic               o_wrap
);

`ifdef SEG7_COMMON_ANODE_EN
    localparam logic [SEG_W-1:0] SEG_INV = '1;
`else
    localparam logic [SEG_W-1:0] SEG_INV = '0;
`endif

    localparam logic [DIGIT_W-1:0] MAX_V    = DIGIT_W'(MAX_COUNT);
    localparam logic [SEG_W-1:0]   DISP_RST = SEG_PATTERN[0] ^ SEG_INV;

    logic                tick;
    logic [DIGIT_W-1:0]  counter_q, counter_d;
    logic [SEG_W-1:0]    display_q, display_d;
    logic                wrap_q, wrap_d;

    seg7_prescaler #(
        .DIV_COUNT (DIV_COUNT)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .o_tick (tick)
    );

    always_comb begin
        counter_d = counter_q;
        wrap_d    = 1'b0;
        if (i_clear) begin
            counter_d = '0;
        end else if (tick) begin
            if (i_dir) begin
                wrap_d    = (counter_q == MAX_V);
                counter_d = wrap_d ? '0 : counter_q + DIGIT_W'(1);
            end else begin
                wrap_d    = (counter_q == '0);
                counter_d = wrap_d ? MAX_V : counter_q - DIGIT_W'(1);
            end
        end
        // Decoding the next value keeps display and counter on the same edge.
        display_d = seg_decode(counter_d) ^ SEG_INV;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            counter_q <= '0;
            display_q <= DISP_RST;
            wrap_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            display_q <= display_d;
            wrap_q    <= wrap_d;
        end
    end

    assign o_counter = counter_q;
    assign o_display = display_q;
    assign o_tick    = tick;
    assign o_wrap    = wrap_q;
    assign {a, b, c, d, e, f, g} = display_q;

endmodule
